// File: rtl/ps2_mouse_pkg.sv
// Shared PS/2 mouse command/response codes, controller state encoding and packet layout.
// The sample-rate states exist only when PS2_MOUSE_CTRL_SAMPLE_RATE_EN is defined.
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] DEV_ID_MOUSE = 8'h00;

    typedef enum logic [3:0] {
        IDLE,
        SEND_RST,
        WAIT_RST_ACK,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_EN_ACK,
        STREAM,
        FAIL
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
        ,
        SEND_RATE_CMD,
        WAIT_RATE_CMD_ACK,
        SEND_RATE_VAL,
        WAIT_RATE_VAL_ACK
`endif
    } state_t;

    typedef struct packed {
        logic [7:0] byte2;
        logic [7:0] byte1;
        logic [7:0] byte0;
    } pkt_t;

endpackage

// File: rtl/ps2_mouse_init_ctrl_if.sv
// Byte-level links of the mouse controller: transceiver tx/rx side and packet output side.
// master = controller, slave = transceiver/consumer.
interface ps2_mouse_init_ctrl_if;
    import ps2_mouse_pkg::*;

    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       tx_done_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_err_i;
    pkt_t       pkt_o;
    logic       pkt_valid_o;
    logic       pkt_ack_i;

    modport master (
        output tx_data_o, tx_valid_o, pkt_o, pkt_valid_o,
        input  tx_ready_i, tx_done_i, rx_data_i, rx_valid_i, rx_err_i, pkt_ack_i
    );

    modport slave (
        input  tx_data_o, tx_valid_o, pkt_o, pkt_valid_o,
        output tx_ready_i, tx_done_i, rx_data_i, rx_valid_i, rx_err_i, pkt_ack_i
    );

endinterface

// File: rtl/ps2_pkt_assembler.sv
// Frames streamed mouse bytes into 3-byte packets with bit3 sync, gap resync,
// a single hold register and a sticky overflow flag.
module ps2_pkt_assembler
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned PKT_GAP_CYC = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    input  logic       rx_err_i,
    input  logic       pkt_ack_i,
    output pkt_t       pkt_o,
    output logic       pkt_valid_o,
    output logic       overflow_o
);

    localparam int unsigned GAP_W = $clog2(PKT_GAP_CYC + 2);

    logic [1:0]       idx_q, idx_d;
    logic [7:0]       b0_q, b0_d;
    logic [7:0]       b1_q, b1_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    pkt_t             pkt_q, pkt_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        idx_d = idx_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        pkt_d = pkt_q;
        vld_d = vld_q;
        ovf_d = ovf_q;
        gap_d = (gap_q == '1) ? gap_q : gap_q + 1'b1;

        // Ack is applied first so a completion in the same cycle can reload the holder.
        if (pkt_ack_i) vld_d = 1'b0;

        if (!en_i) begin
            idx_d = 2'd0;
            gap_d = '0;
        end else if (rx_valid_i) begin
            gap_d = '0;
            if (rx_err_i) begin
                idx_d = 2'd0;
            end else begin
                case (idx_q)
                    2'd0: begin
                        if (rx_data_i[3]) begin
                            b0_d  = rx_data_i;
                            idx_d = 2'd1;
                        end
                    end
                    2'd1: begin
                        b1_d  = rx_data_i;
                        idx_d = 2'd2;
                    end
                    default: begin
                        idx_d = 2'd0;
                        if (!vld_q || pkt_ack_i) begin
                            pkt_d = {rx_data_i, b1_q, b0_q};
                            vld_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                endcase
            end
        end else if (idx_q != 2'd0 && gap_q >= GAP_W'(PKT_GAP_CYC)) begin
            idx_d = 2'd0;
        end

        if (clr_i) begin
            idx_d = 2'd0;
            vld_d = 1'b0;
            ovf_d = 1'b0;
            gap_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        b0_q <= b0_d;
        b1_q <= b1_d;
        if (rst_i) begin
            idx_q <= 2'd0;
            gap_q <= '0;
            pkt_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            gap_q <= gap_d;
            pkt_q <= pkt_d;
            vld_q <= vld_d;
            ovf_q <= ovf_d;
        end
    end

    assign pkt_o       = pkt_q;
    assign pkt_valid_o = vld_q;
    assign overflow_o  = ovf_q;

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer (reset, BAT, ID, enable) with timeouts/retries, then packet framing.
// Define PS2_MOUSE_CTRL_SAMPLE_RATE_EN to insert the set-sample-rate exchange after the ID check.
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT_CYC = 2_500_000,
    parameter int unsigned BAT_TIMEOUT_CYC  = 50_000_000,
    parameter int unsigned PKT_GAP_CYC      = 1_000_000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter logic [7:0]  SAMPLE_RATE      = 8'd100
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    ps2_mouse_init_ctrl_if.master bus,
    output logic                  ready_o,
    output logic                  err_o,
    output logic                  overflow_o,
    output logic [1:0]            retries_o
);

    localparam int unsigned TMR_MAX = (BAT_TIMEOUT_CYC > RESP_TIMEOUT_CYC) ? BAT_TIMEOUT_CYC
                                                                           : RESP_TIMEOUT_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state_q, state_d;
    logic               sent_q, sent_d;
    logic [1:0]         retries_q, retries_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TMR_W-1:0]   tmr_lim;
    logic               start_ok, expired, byte_ok, retry, resend;

    function automatic logic [7:0] cmd_of(state_t s);
        case (s)
            SEND_RST:      return CMD_RESET;
            SEND_EN:       return CMD_ENABLE;
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
            SEND_RATE_CMD: return CMD_SET_RATE;
            SEND_RATE_VAL: return SAMPLE_RATE;
`endif
            default:       return 8'h00;
        endcase
    endfunction

    function automatic state_t wait_of(state_t s);
        case (s)
            SEND_RST:      return WAIT_RST_ACK;
            SEND_EN:       return WAIT_EN_ACK;
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
            SEND_RATE_CMD: return WAIT_RATE_CMD_ACK;
            SEND_RATE_VAL: return WAIT_RATE_VAL_ACK;
`endif
            default:       return IDLE;
        endcase
    endfunction

    function automatic state_t ack_next_of(state_t s);
        case (s)
            WAIT_RST_ACK:      return WAIT_BAT;
            WAIT_EN_ACK:       return STREAM;
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
            WAIT_RATE_CMD_ACK: return SEND_RATE_VAL;
            WAIT_RATE_VAL_ACK: return SEND_EN;
`endif
            default:           return IDLE;
        endcase
    endfunction

    function automatic state_t resend_of(state_t s);
        case (s)
            WAIT_EN_ACK:       return SEND_EN;
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
            WAIT_RATE_CMD_ACK: return SEND_RATE_CMD;
            WAIT_RATE_VAL_ACK: return SEND_RATE_VAL;
`endif
            default:           return SEND_RST;
        endcase
    endfunction

`ifndef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
    logic [7:0] unused_rate;
    assign unused_rate = SAMPLE_RATE;
`endif

    assign tmr_lim  = (state_q == WAIT_BAT) ? TMR_W'(BAT_TIMEOUT_CYC - 1)
                                            : TMR_W'(RESP_TIMEOUT_CYC - 1);
    assign start_ok = start_i && (state_q inside {IDLE, STREAM, FAIL});
    // A byte arriving on the final timer cycle takes priority over expiry.
    assign expired  = (timer_q == tmr_lim) && !bus.rx_valid_i;
    assign byte_ok  = bus.rx_valid_i && !bus.rx_err_i;

    always_comb begin
        state_d        = state_q;
        sent_d         = sent_q;
        retries_d      = retries_q;
        timer_d        = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        retry          = 1'b0;
        resend         = 1'b0;
        bus.tx_valid_o = 1'b0;
        bus.tx_data_o  = 8'h00;

        case (state_q)
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
            SEND_RATE_CMD, SEND_RATE_VAL,
`endif
            SEND_RST, SEND_EN: begin
                bus.tx_data_o  = cmd_of(state_q);
                bus.tx_valid_o = !sent_q;
                if (!sent_q && bus.tx_ready_i) begin
                    sent_d = 1'b1;
                end else if (sent_q && bus.tx_done_i) begin
                    sent_d  = 1'b0;
                    timer_d = '0;
                    state_d = wait_of(state_q);
                end
            end
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
            WAIT_RATE_CMD_ACK, WAIT_RATE_VAL_ACK,
`endif
            WAIT_RST_ACK, WAIT_EN_ACK: begin
                if (byte_ok && bus.rx_data_i == RSP_ACK) begin
                    state_d = ack_next_of(state_q);
                    timer_d = '0;
                end else if (byte_ok && bus.rx_data_i == RSP_RESEND) begin
                    resend = 1'b1;
                end else if (bus.rx_valid_i || expired) begin
                    retry = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (byte_ok && bus.rx_data_i == RSP_BAT_OK) begin
                    state_d = WAIT_ID;
                    timer_d = '0;
                end else if (bus.rx_valid_i || expired) begin
                    retry = 1'b1;
                end
            end
            WAIT_ID: begin
                if (byte_ok && bus.rx_data_i == DEV_ID_MOUSE) begin
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
                    state_d = SEND_RATE_CMD;
`else
                    state_d = SEND_EN;
`endif
                end else if (bus.rx_valid_i || expired) begin
                    retry = 1'b1;
                end
            end
            IDLE, STREAM, FAIL: ;
            default: state_d = IDLE;
        endcase

        if (retry || resend) begin
            if (retries_q == 2'(MAX_RETRIES)) begin
                state_d = FAIL;
            end else begin
                retries_d = retries_q + 2'd1;
                state_d   = resend ? resend_of(state_q) : SEND_RST;
            end
        end

        if (start_ok) begin
            state_d   = SEND_RST;
            sent_d    = 1'b0;
            retries_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sent_q    <= 1'b0;
            retries_q <= 2'd0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            sent_q    <= sent_d;
            retries_q <= retries_d;
            timer_q   <= timer_d;
        end
    end

    ps2_pkt_assembler #(
        .PKT_GAP_CYC (PKT_GAP_CYC)
    ) u_pkt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (state_q == STREAM),
        .clr_i       (start_ok),
        .rx_data_i   (bus.rx_data_i),
        .rx_valid_i  (bus.rx_valid_i),
        .rx_err_i    (bus.rx_err_i),
        .pkt_ack_i   (bus.pkt_ack_i),
        .pkt_o       (bus.pkt_o),
        .pkt_valid_o (bus.pkt_valid_o),
        .overflow_o  (overflow_o)
    );

    assign ready_o   = (state_q == STREAM);
    assign err_o     = (state_q == FAIL);
    assign retries_o = retries_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl: bring-up, resend/timeout exhaustion, BAT failure,
// packet framing, overflow, gap resync and mid-init reset.
module tb_ps2_mouse_init_ctrl;

    localparam int unsigned RESP_TO = 100;
    localparam int unsigned BAT_TO  = 300;
    localparam int unsigned GAP     = 50;
    localparam logic [7:0]  RATE    = 8'd100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready, err, ovf;
    logic [1:0] retries;
    int         checks = 0;
    int         errors = 0;

    ps2_mouse_init_ctrl_if bus ();

    ps2_mouse_init_ctrl #(
        .RESP_TIMEOUT_CYC (RESP_TO),
        .BAT_TIMEOUT_CYC  (BAT_TO),
        .PKT_GAP_CYC      (GAP),
        .MAX_RETRIES      (3),
        .SAMPLE_RATE      (RATE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .bus        (bus.master),
        .ready_o    (ready),
        .err_o      (err),
        .overflow_o (ovf),
        .retries_o  (retries)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rx(input logic [7:0] d);
        bus.rx_data_i  = d;
        bus.rx_valid_i = 1'b1;
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic ack();
        bus.pkt_ack_i = 1'b1;
        @(negedge clk);
        bus.pkt_ack_i = 1'b0;
    endtask

    // Accept one command byte from the DUT and report it shifted out.
    task automatic xfer(input logic [7:0] exp, input string tag);
        int n = 0;
        while (!bus.tx_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.tx_valid_o), 32'd1);
        chk({tag, "_data"}, 32'(bus.tx_data_o), 32'(exp));
        bus.tx_ready_i = 1'b1;
        @(negedge clk);
        bus.tx_ready_i = 1'b0;
        chk({tag, "_drop"}, 32'(bus.tx_valid_o), 32'd0);
        @(negedge clk);
        bus.tx_done_i = 1'b1;
        @(negedge clk);
        bus.tx_done_i = 1'b0;
    endtask

    // Called on the first response-timer cycle; returns on cycle RESP_TO+1.
    task automatic wait_timeout(input string tag);
        repeat (RESP_TO - 1) @(negedge clk);
        chk({tag, "_early"}, 32'(bus.tx_valid_o), 32'd0);
        @(negedge clk);
    endtask

    task automatic after_rst_ack(input logic [1:0] exp_retries, input string tag);
        rx(8'hAA);
        rx(8'h00);
`ifdef PS2_MOUSE_CTRL_SAMPLE_RATE_EN
        xfer(8'hF3, {tag, "_f3"});
        rx(8'hFA);
        xfer(RATE, {tag, "_rate"});
        rx(8'hFA);
`endif
        xfer(8'hF4, {tag, "_f4"});
        rx(8'hFA);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_retries"}, 32'(retries), 32'(exp_retries));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_ready_i = 1'b0;
        bus.tx_done_i  = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.rx_err_i   = 1'b0;
        bus.pkt_ack_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_txv", 32'(bus.tx_valid_o), 32'd0);
        chk("rst_pktv", 32'(bus.pkt_valid_o), 32'd0);
        chk("rst_retries", 32'(retries), 32'd0);

        // Happy path
        pulse_start();
        xfer(8'hFF, "hp_ff");
        rx(8'hFA);
        after_rst_ack(2'd0, "hp");

        // Framing: leading byte without bit3 is discarded
        rx(8'h00);
        rx(8'h08);
        rx(8'h05);
        chk("frm_pre", 32'(bus.pkt_valid_o), 32'd0);
        rx(8'hFB);
        chk("frm_vld", 32'(bus.pkt_valid_o), 32'd1);
        chk("frm_pkt", 32'(bus.pkt_o), 32'h00FB0508);

        // Overflow: second packet dropped while first is unacked
        rx(8'h08);
        rx(8'h11);
        rx(8'h22);
        chk("ovf_pkt", 32'(bus.pkt_o), 32'h00FB0508);
        chk("ovf_flag", 32'(ovf), 32'd1);
        rx(8'h18);
        rx(8'h33);
        bus.pkt_ack_i = 1'b1;
        rx(8'h44);
        bus.pkt_ack_i = 1'b0;
        chk("ackc_pkt", 32'(bus.pkt_o), 32'h00443318);
        chk("ackc_vld", 32'(bus.pkt_valid_o), 32'd1);
        chk("ackc_ovf", 32'(ovf), 32'd1);
        ack();
        chk("ack_vld", 32'(bus.pkt_valid_o), 32'd0);

        // Gap: exactly GAP idle cycles keeps the index, GAP+1 resyncs
        rx(8'h09);
        repeat (GAP) @(negedge clk);
        rx(8'h0A);
        rx(8'h0B);
        chk("gap_ok_pkt", 32'(bus.pkt_o), 32'h000B0A09);
        ack();
        rx(8'h19);
        repeat (GAP + 1) @(negedge clk);
        rx(8'h2A);
        rx(8'h3B);
        chk("gap_rs_vld", 32'(bus.pkt_valid_o), 32'd0);
        rx(8'h4C);
        chk("gap_rs_pkt", 32'(bus.pkt_o), 32'h004C3B2A);
        ack();

        // Resend then timeouts until exhausted
        pulse_start();
        chk("st_ovf_clr", 32'(ovf), 32'd0);
        chk("st_ready", 32'(ready), 32'd0);
        xfer(8'hFF, "rs_ff1");
        rx(8'hFE);
        chk("rs_retries", 32'(retries), 32'd1);
        xfer(8'hFF, "rs_ff2");
        wait_timeout("rs_to1");
        chk("rs_r2", 32'(retries), 32'd2);
        xfer(8'hFF, "rs_ff3");
        wait_timeout("rs_to2");
        chk("rs_r3", 32'(retries), 32'd3);
        xfer(8'hFF, "rs_ff4");
        wait_timeout("rs_to3");
        chk("rs_err", 32'(err), 32'd1);
        chk("rs_err_txv", 32'(bus.tx_valid_o), 32'd0);

        // Pure silence: four reset sends then FAIL
        pulse_start();
        chk("sil_err_clr", 32'(err), 32'd0);
        chk("sil_r0", 32'(retries), 32'd0);
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, "sil_ff");
            wait_timeout("sil_to");
        end
        chk("sil_err", 32'(err), 32'd1);
        chk("sil_retries", 32'(retries), 32'd3);

        // BAT failure; ACK on the last timer cycle beats the timeout
        pulse_start();
        xfer(8'hFF, "bat_ff1");
        repeat (RESP_TO - 1) @(negedge clk);
        rx(8'hFA);
        chk("bat_edge_txv", 32'(bus.tx_valid_o), 32'd0);
        chk("bat_edge_r", 32'(retries), 32'd0);
        rx(8'hFC);
        chk("bat_r1", 32'(retries), 32'd1);
        xfer(8'hFF, "bat_ff2");
        rx(8'hFA);
        after_rst_ack(2'd1, "bat");

        // Reset while in WAIT_BAT, then full rerun
        pulse_start();
        xfer(8'hFF, "mr_ff");
        rx(8'hFA);
        pulse_start();
        chk("mr_start_ign", 32'(bus.tx_valid_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_ready", 32'(ready), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_retries", 32'(retries), 32'd0);
        chk("mr_txv", 32'(bus.tx_valid_o), 32'd0);
        chk("mr_txd", 32'(bus.tx_data_o), 32'd0);
        chk("mr_pkt", 32'(bus.pkt_o), 32'd0);
        chk("mr_ovf", 32'(ovf), 32'd0);
        pulse_start();
        xfer(8'hFF, "mr2_ff");
        rx(8'hFA);
        after_rst_ack(2'd0, "mr2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
